// File: rtl/ac_motor_switch_decoder_pkg.sv
// Shared vector codes, switch decode, adjacency and sector helpers, and the FSM states
// for the switch-command decoder.
package ac_motor_switch_decoder_pkg;

  typedef enum logic {SYNC = 1'b0, MEAS = 1'b1} state_t;

  localparam logic [2:0] VEC_0 = 3'd0;
  localparam logic [2:0] VEC_1 = 3'd1;
  localparam logic [2:0] VEC_2 = 3'd2;
  localparam logic [2:0] VEC_3 = 3'd3;
  localparam logic [2:0] VEC_4 = 3'd4;
  localparam logic [2:0] VEC_5 = 3'd5;
  localparam logic [2:0] VEC_6 = 3'd6;
  localparam logic [2:0] VEC_7 = 3'd7;

  // s is {s1, s2, s3}
  function automatic logic [2:0] decode(input logic [2:0] s);
    logic [2:0] v;
    case (s)
      3'b000:  v = VEC_0;
      3'b100:  v = VEC_1;
      3'b110:  v = VEC_2;
      3'b010:  v = VEC_3;
      3'b011:  v = VEC_4;
      3'b001:  v = VEC_5;
      3'b101:  v = VEC_6;
      default: v = VEC_7;
    endcase
    return v;
  endfunction

  function automatic logic [2:0] encode(input logic [2:0] v);
    logic [2:0] s;
    case (v)
      VEC_0:   s = 3'b000;
      VEC_1:   s = 3'b100;
      VEC_2:   s = 3'b110;
      VEC_3:   s = 3'b010;
      VEC_4:   s = 3'b011;
      VEC_5:   s = 3'b001;
      VEC_6:   s = 3'b101;
      default: s = 3'b111;
    endcase
    return s;
  endfunction

  // True when the two vectors differ in exactly one switch.
  function automatic logic adjacent(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] x;
    x = encode(a) ^ encode(b);
    return (x == 3'b001) || (x == 3'b010) || (x == 3'b100);
  endfunction

  function automatic logic is_active(input logic [2:0] v);
    return (v != VEC_0) && (v != VEC_7);
  endfunction

  function automatic logic [2:0] next_vec(input logic [2:0] k);
    return (k == VEC_6) ? VEC_1 : k + 3'd1;
  endfunction

  // Sector k when {a, b} == {k, k%6+1} in either order, else 0.
  function automatic logic [2:0] sector_from_pair(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] k;
    k = 3'd0;
    if (is_active(a) && is_active(b)) begin
      if (b == next_vec(a)) begin
        k = a;
      end else if (a == next_vec(b)) begin
        k = b;
      end
    end
    return k;
  endfunction

endpackage

// File: rtl/ac_motor_switch_decoder_if.sv
// Switch-command inputs and measurement/error outputs of the decoder.
// master drives the switches (controller or bench); slave is the decoder.
interface ac_motor_switch_decoder_if #(
  parameter int COUNT_W = 15
);
  logic               s1;
  logic               s2;
  logic               s3;
  logic               err_clr;
  logic [2:0]         vec;
  logic [COUNT_W-1:0] t_0;
  logic [COUNT_W-1:0] t_1;
  logic [COUNT_W-1:0] t_2;
  logic [COUNT_W-1:0] t_7;
  logic [2:0]         sector;
  logic               meas_valid;
  logic               err_trans;
  logic               err_seq;
  logic               stall;

  modport master (
    output s1, s2, s3, err_clr,
    input  vec, t_0, t_1, t_2, t_7, sector, meas_valid, err_trans, err_seq, stall
  );

  modport slave (
    input  s1, s2, s3, err_clr,
    output vec, t_0, t_1, t_2, t_7, sector, meas_valid, err_trans, err_seq, stall
  );
endinterface

// File: rtl/ac_motor_dwell_acc.sv
// Saturating dwell accumulator; cap is this cycle's total including a pending increment.
// Clear wins over increment; no wrap at full scale.
module ac_motor_dwell_acc #(
  parameter int COUNT_W = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               clr,
  output logic [COUNT_W-1:0] cap
);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic [COUNT_W-1:0] cnt;

  always_comb begin
    cap = cnt;
    if (inc && (cnt != CNT_MAX)) begin
      cap = cnt + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= cap;
    end
  end
endmodule

// File: rtl/ac_motor_switch_decoder.sv
// Decodes s1..s3 into space vectors, measures per-period dwell times and sector, flags errors.
// vec is one cycle behind the switches; t_*/sector update with meas_valid the cycle after a return to 0.
module ac_motor_switch_decoder
  import ac_motor_switch_decoder_pkg::*;
#(
  parameter int COUNT_W = 15,
  parameter int TIMEOUT = 65535
) (
  input logic                      clk,
  input logic                      rst_n,
  ac_motor_switch_decoder_if.slave bus
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [2:0]         dec;
  logic [2:0]         vec_q;
  state_t             state;
  state_t             state_n;
  logic               close;
  logic               acc_en;
  logic               report;

  logic [2:0]         a_id, b_id, a_id_n, b_id_n;
  logic               seq_bad, seq_bad_n;
  logic               inc_a, inc_b, third;
  logic [COUNT_W-1:0] z0_cap, z7_cap, a_cap, b_cap;

  logic [2:0]         pair_k;
  logic [2:0]         sector_n;
  logic [COUNT_W-1:0] t1_n, t2_n;
  logic               pair_bad;

  logic [COUNT_W-1:0] t0_q, t1_q, t2_q, t7_q;
  logic [2:0]         sector_q;
  logic               meas_valid_q;
  logic               err_trans_q, err_seq_q, stall_q;
  logic               trans_evt, seq_evt, stall_evt;
  logic [WD_W-1:0]    wd;

  assign dec   = decode({bus.s1, bus.s2, bus.s3});
  assign close = (vec_q != VEC_0) && (dec == VEC_0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SYNC;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      SYNC:    if (close) state_n = MEAS;
      MEAS:    state_n = MEAS;
      default: state_n = SYNC;
    endcase
  end

  // The first period after reset is partial, so SYNC only waits for a clean start.
  always_comb begin
    acc_en = (state == MEAS);
    report = (state == MEAS) && close;
  end

  always_comb begin
    a_id_n = a_id;
    b_id_n = b_id;
    inc_a  = 1'b0;
    inc_b  = 1'b0;
    third  = 1'b0;
    if (acc_en && is_active(vec_q)) begin
      if ((a_id == VEC_0) || (a_id == vec_q)) begin
        a_id_n = vec_q;
        inc_a  = 1'b1;
      end else if ((b_id == VEC_0) || (b_id == vec_q)) begin
        b_id_n = vec_q;
        inc_b  = 1'b1;
      end else begin
        third  = 1'b1;
      end
    end
    seq_bad_n = seq_bad | third;
  end

  ac_motor_dwell_acc #(.COUNT_W(COUNT_W)) u_acc_z0 (
    .clk(clk), .rst_n(rst_n), .inc(acc_en && (vec_q == VEC_0)), .clr(close), .cap(z0_cap)
  );
  ac_motor_dwell_acc #(.COUNT_W(COUNT_W)) u_acc_z7 (
    .clk(clk), .rst_n(rst_n), .inc(acc_en && (vec_q == VEC_7)), .clr(close), .cap(z7_cap)
  );
  ac_motor_dwell_acc #(.COUNT_W(COUNT_W)) u_acc_a (
    .clk(clk), .rst_n(rst_n), .inc(inc_a), .clr(close), .cap(a_cap)
  );
  ac_motor_dwell_acc #(.COUNT_W(COUNT_W)) u_acc_b (
    .clk(clk), .rst_n(rst_n), .inc(inc_b), .clr(close), .cap(b_cap)
  );

  // Slot ids/counts include the closing cycle, hence the *_n and cap views here.
  assign pair_k = sector_from_pair(a_id_n, b_id_n);

  always_comb begin
    sector_n = 3'd0;
    t1_n     = '0;
    t2_n     = '0;
    pair_bad = 1'b0;
    if (b_id_n != VEC_0) begin
      if ((pair_k != 3'd0) && !seq_bad_n) begin
        sector_n = pair_k;
        t1_n     = (a_id_n == pair_k) ? a_cap : b_cap;
        t2_n     = (a_id_n == pair_k) ? b_cap : a_cap;
      end else begin
        pair_bad = (pair_k == 3'd0);
      end
    end else if (a_id_n != VEC_0) begin
      t1_n = a_cap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q        <= VEC_0;
      a_id         <= VEC_0;
      b_id         <= VEC_0;
      seq_bad      <= 1'b0;
      meas_valid_q <= 1'b0;
      t0_q         <= '0;
      t1_q         <= '0;
      t2_q         <= '0;
      t7_q         <= '0;
      sector_q     <= 3'd0;
    end else begin
      vec_q        <= dec;
      meas_valid_q <= report;
      if (close) begin
        a_id    <= VEC_0;
        b_id    <= VEC_0;
        seq_bad <= 1'b0;
      end else begin
        a_id    <= a_id_n;
        b_id    <= b_id_n;
        seq_bad <= seq_bad_n;
      end
      if (report) begin
        t0_q     <= z0_cap;
        t7_q     <= z7_cap;
        t1_q     <= t1_n;
        t2_q     <= t2_n;
        sector_q <= sector_n;
      end
    end
  end

  assign trans_evt = (dec != vec_q) && !adjacent(dec, vec_q);
  assign seq_evt   = third || (report && pair_bad);
  assign stall_evt = !close && (wd == WD_LAST);

  // A fresh error event outranks a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd          <= '0;
      err_trans_q <= 1'b0;
      err_seq_q   <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      if (close) begin
        wd <= '0;
      end else if (wd != WD_MAX) begin
        wd <= wd + WD_W'(1);
      end
      err_trans_q <= trans_evt | (err_trans_q & ~bus.err_clr);
      err_seq_q   <= seq_evt   | (err_seq_q   & ~bus.err_clr);
      stall_q     <= stall_evt | (stall_q     & ~bus.err_clr);
    end
  end

  assign bus.vec        = vec_q;
  assign bus.t_0        = t0_q;
  assign bus.t_1        = t1_q;
  assign bus.t_2        = t2_q;
  assign bus.t_7        = t7_q;
  assign bus.sector     = sector_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.err_trans  = err_trans_q;
  assign bus.err_seq    = err_seq_q;
  assign bus.stall      = stall_q;

endmodule
